// File: rtl/axi_llc_pkg.sv
// Shared LLC configuration, channel payload types and helpers for the refill R master.
package axi_llc_pkg;

    typedef struct packed {
        int unsigned NumBlocks;
        int unsigned BlockOffsetLength;
        int unsigned ByteOffsetLength;
        int unsigned IndexLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
    } llc_axi_cfg_t;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;
    localparam int unsigned BlkW  = 2;
    localparam int unsigned IdxW  = 8;
    localparam int unsigned WayW  = 4;

    localparam llc_cfg_t DefaultCfg = '{NumBlocks: 32'd4, BlockOffsetLength: 32'd2,
                                        ByteOffsetLength: 32'd3, IndexLength: 32'd8};
    localparam llc_axi_cfg_t DefaultAxiCfg = '{AddrWidthFull: 32'd32, DataWidthFull: 32'd64};

    localparam logic [1:0] RespOkay = 2'b00;

    typedef enum logic [1:0] {
        TagUnit   = 2'd0,
        EvictUnit = 2'd1,
        RefilUnit = 2'd2,
        WChanUnit = 2'd3
    } cache_unit_e;

    typedef struct packed {
        logic [AddrW-1:0] a_x_addr;
        logic [WayW-1:0]  way_ind;
        logic             refill;
    } llc_desc_t;

    typedef struct packed {
        cache_unit_e        cache_unit;
        logic [WayW-1:0]    way_ind;
        logic [IdxW-1:0]    line_addr;
        logic [BlkW-1:0]    blk_offset;
        logic               we;
        logic [DataW/8-1:0] strb;
        logic [DataW-1:0]   data;
    } llc_way_inp_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } llc_r_chan_t;

    // A beat is flagged when the slave reports an error or its last marker disagrees with the count.
    function automatic logic beat_error(input logic [1:0] resp, input logic last,
                                        input logic expect_last);
        return (resp != RespOkay) || (last != expect_last);
    endfunction

endpackage

// File: rtl/axi_llc_r_master_fifo.sv
// Two-entry non-fall-through buffer between the AXI R channel and the data way write port.
module axi_llc_r_master_fifo #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 testmode_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DataWidth-1:0] mem_r [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           cnt_r;
    logic                 unused_testmode_s;

    assign unused_testmode_s = testmode_i;
    assign full_o  = (cnt_r == 2'd2);
    assign empty_o = (cnt_r == 2'd0);
    assign data_o  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_r[0] <= {DataWidth{1'b0}};
            mem_r[1] <= {DataWidth{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_i) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_r + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

endmodule

// File: rtl/axi_llc_r_master.sv
// LLC refill master: collects one cache line of R beats into a data way, then forwards the descriptor.
module axi_llc_r_master
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t     Cfg       = DefaultCfg,
    parameter llc_axi_cfg_t AxiCfg    = DefaultAxiCfg,
    parameter type          desc_t    = llc_desc_t,
    parameter type          way_inp_t = llc_way_inp_t,
    parameter type          r_chan_t  = llc_r_chan_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     test_i,
    input  desc_t    desc_i,
    input  logic     desc_valid_i,
    output logic     desc_ready_o,
    output desc_t    desc_o,
    output logic     desc_valid_o,
    input  logic     desc_ready_i,
    input  r_chan_t  r_chan_mst_i,
    input  logic     r_chan_valid_i,
    output logic     r_chan_ready_o,
    output way_inp_t way_inp_o,
    output logic     way_inp_valid_o,
    input  logic     way_inp_ready_i,
    output logic     refill_err_o
);

    localparam int unsigned BolW    = Cfg.BlockOffsetLength;
    localparam int unsigned AddrLsb = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_SEND   = 2'd2
    } r_mst_state_e;

    r_mst_state_e                      state_r, state_n_s;
    desc_t                             desc_r;
    logic [BolW-1:0]                   beat_cnt_r;
    logic [BolW-1:0]                   wr_cnt_r;
    logic                              beat_done_r;
    logic                              load_desc_s;
    logic                              r_hs_s;
    logic                              way_hs_s;
    logic                              fifo_full_s;
    logic                              fifo_empty_s;
    logic [AxiCfg.DataWidthFull-1:0]   fifo_data_s;

    assign r_hs_s   = r_chan_valid_i & r_chan_ready_o;
    assign way_hs_s = way_inp_valid_o & way_inp_ready_i;
    assign desc_o   = desc_r;

    axi_llc_r_master_fifo #(
        .DataWidth (AxiCfg.DataWidthFull)
    ) i_refill_data_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .testmode_i (test_i),
        .push_i     (r_hs_s),
        .data_i     (r_chan_mst_i.data),
        .pop_i      (way_hs_s),
        .data_o     (fifo_data_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s)
    );

    // Next state and descriptor handshakes; SEND with a ready consumer acts as IDLE in the same cycle.
    always_comb begin
        state_n_s    = state_r;
        load_desc_s  = 1'b0;
        desc_ready_o = 1'b0;
        desc_valid_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    load_desc_s = 1'b1;
                    state_n_s   = desc_i.refill ? ST_REFILL : ST_SEND;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (way_hs_s && (wr_cnt_r == {BolW{1'b1}})) begin
                    state_n_s = ST_SEND;
                end else begin
                    state_n_s = ST_REFILL;
                end
            end
            ST_SEND: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    desc_ready_o = 1'b1;
                    if (desc_valid_i) begin
                        load_desc_s = 1'b1;
                        state_n_s   = desc_i.refill ? ST_REFILL : ST_SEND;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    state_n_s = ST_SEND;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // R acceptance, way request and beat error flag; ready depends only on registered state.
    always_comb begin
        r_chan_ready_o  = 1'b0;
        way_inp_valid_o = 1'b0;
        refill_err_o    = 1'b0;
        way_inp_o            = '0;
        way_inp_o.cache_unit = RefilUnit;
        way_inp_o.way_ind    = desc_r.way_ind;
        way_inp_o.line_addr  = desc_r.a_x_addr[AddrLsb +: Cfg.IndexLength];
        way_inp_o.blk_offset = wr_cnt_r;
        way_inp_o.we         = 1'b1;
        way_inp_o.strb       = '1;
        way_inp_o.data       = fifo_data_s;
        if (state_r == ST_REFILL) begin
            r_chan_ready_o  = ~fifo_full_s & ~beat_done_r;
            way_inp_valid_o = ~fifo_empty_s;
            refill_err_o    = r_hs_s & beat_error(r_chan_mst_i.resp, r_chan_mst_i.last,
                                  beat_cnt_r == BolW'(Cfg.NumBlocks - 32'd1));
        end else begin
            r_chan_ready_o  = 1'b0;
            way_inp_valid_o = 1'b0;
            refill_err_o    = 1'b0;
        end
    end

    // State, descriptor and beat/write counters; a descriptor load restarts both counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            desc_r      <= '0;
            beat_cnt_r  <= {BolW{1'b0}};
            wr_cnt_r    <= {BolW{1'b0}};
            beat_done_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            if (load_desc_s) begin
                desc_r      <= desc_i;
                beat_cnt_r  <= {BolW{1'b0}};
                wr_cnt_r    <= {BolW{1'b0}};
                beat_done_r <= 1'b0;
            end else begin
                if (r_hs_s) begin
                    beat_cnt_r <= beat_cnt_r + BolW'(1);
                    if (beat_cnt_r == {BolW{1'b1}}) begin
                        beat_done_r <= 1'b1;
                    end
                end
                if (way_hs_s) begin
                    wr_cnt_r <= wr_cnt_r + BolW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_llc_r_master.sv
// Directed bench for the LLC refill R master: a per-cycle vector table plus multi-cycle sequences.
module tb_axi_llc_r_master;
    import axi_llc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         test;
    llc_desc_t    desc_in, desc_out;
    logic         desc_valid, desc_ready_out, desc_valid_out, desc_ready_in;
    llc_r_chan_t  r_chan;
    logic         r_valid, r_ready;
    llc_way_inp_t way_inp;
    logic         way_valid, way_ready;
    logic         refill_err;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] beat_resp [4];
    logic       beat_last [4];
    logic       exp_err   [4];

    always #5 clk = ~clk;

    axi_llc_r_master dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .test_i          (test),
        .desc_i          (desc_in),
        .desc_valid_i    (desc_valid),
        .desc_ready_o    (desc_ready_out),
        .desc_o          (desc_out),
        .desc_valid_o    (desc_valid_out),
        .desc_ready_i    (desc_ready_in),
        .r_chan_mst_i    (r_chan),
        .r_chan_valid_i  (r_valid),
        .r_chan_ready_o  (r_ready),
        .way_inp_o       (way_inp),
        .way_inp_valid_o (way_valid),
        .way_inp_ready_i (way_ready),
        .refill_err_o    (refill_err)
    );

    typedef struct {
        logic        dv;
        logic        rf;
        logic        rv;
        logic [63:0] rd;
        logic        rl;
        logic        e_dready;
        logic        e_dvalid;
        logic        e_rready;
        logic        e_wvalid;
        logic [1:0]  e_blk;
        logic [63:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic rf, input logic rv, input logic [63:0] rd,
                                input logic rl, input logic e_dready, input logic e_dvalid,
                                input logic e_rready, input logic e_wvalid, input logic [1:0] e_blk,
                                input logic [63:0] e_data);
        vec_t v;
        v.dv = dv; v.rf = rf; v.rv = rv; v.rd = rd; v.rl = rl;
        v.e_dready = e_dready; v.e_dvalid = e_dvalid; v.e_rready = e_rready;
        v.e_wvalid = e_wvalid; v.e_blk = e_blk; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Loads a refill descriptor, feeds four beats, checks every write and error pulse, ends in SEND.
    task automatic refill(input logic [63:0] base, input int stall, input logic [31:0] addr,
                          input logic [3:0] way, input logic [7:0] exp_line, input int exp_cycles);
        int beats;
        int writes;
        int cyc;
        @(negedge clk);
        desc_in.a_x_addr = addr; desc_in.way_ind = way; desc_in.refill = 1'b1;
        desc_valid = 1'b1; desc_ready_in = 1'b1; r_valid = 1'b0; way_ready = 1'b0;
        #1 chk("load_ready", desc_ready_out, 1'b1);
        beats = 0; writes = 0; cyc = 0;
        while (writes < 4 && cyc < 40) begin
            @(negedge clk);
            desc_valid = 1'b0; desc_ready_in = 1'b0;
            r_valid = (beats < 4);
            r_chan.data = base + 64'(beats);
            r_chan.resp = beat_resp[beats & 3];
            r_chan.last = beat_last[beats & 3];
            way_ready = (cyc >= stall);
            #1;
            if (stall >= 3 && cyc == stall - 1) begin
                chk("bp_rready", r_ready, 1'b0);
                chk("bp_beats", 64'(beats), 64'd2);
            end
            if (beats >= 4) chk("done_rready", r_ready, 1'b0);
            if (r_valid && r_ready) begin
                chk("beat_err", refill_err, exp_err[beats]);
                beats++;
            end else begin
                chk("idle_err", refill_err, 1'b0);
            end
            if (way_valid && way_ready) begin
                chk("wr_blk", 64'(way_inp.blk_offset), 64'(writes));
                chk("wr_data", way_inp.data, base + 64'(writes));
                chk("wr_ctl", {way_inp.we, way_inp.strb, way_inp.way_ind, 2'(way_inp.cache_unit)},
                    {1'b1, 8'hFF, way, 2'd2});
                chk("wr_line", 64'(way_inp.line_addr), 64'(exp_line));
                writes++;
            end
            cyc++;
        end
        chk("writes", 64'(writes), 64'd4);
        if (exp_cycles > 0) chk("refill_cycles", 64'(cyc), 64'(exp_cycles));
        @(negedge clk);
        r_valid = 1'b0; way_ready = 1'b0;
        #1;
        chk("send_valid", desc_valid_out, 1'b1);
        chk("send_desc", {desc_out.way_ind, desc_out.refill, desc_out.a_x_addr}, {way, 1'b1, addr});
    endtask

    initial begin
        vec_t       tbl [$];
        llc_desc_t  held;
        rst_n = 1'b0; test = 1'b0; desc_in = '0; desc_valid = 1'b0; desc_ready_in = 1'b0;
        r_chan = '0; r_valid = 1'b0; way_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_resp[i] = 2'b00; beat_last[i] = (i == 3); exp_err[i] = 1'b0;
        end
        #12;
        chk("rst_dready", desc_ready_out, 1'b1);
        chk("rst_valids", {desc_valid_out, r_ready, way_valid, refill_err}, 4'b0000);
        chk("rst_desc", 64'(desc_out), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        //           dv    rf    rv    data                   last  dRdy  dVld  rRdy  wVld  blk   wdata
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h0,                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'hDA7A_0000_0000_00D0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'hDA7A_0000_0000_00D1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 64'hDA7A_0000_0000_00D0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'hDA7A_0000_0000_00D2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'hDA7A_0000_0000_00D1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'hDA7A_0000_0000_00D3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 64'hDA7A_0000_0000_00D2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'h0,                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 64'hDA7A_0000_0000_00D3));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 64'h0,                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0));

        foreach (tbl[i]) begin
            @(negedge clk);
            desc_in.a_x_addr = 32'h0000_0AA0; desc_in.way_ind = 4'd2; desc_in.refill = tbl[i].rf;
            desc_valid = tbl[i].dv; desc_ready_in = 1'b1; way_ready = 1'b1;
            r_valid = tbl[i].rv; r_chan.data = tbl[i].rd; r_chan.resp = 2'b00; r_chan.last = tbl[i].rl;
            #1;
            chk($sformatf("v%0d_dready", i), desc_ready_out, tbl[i].e_dready);
            chk($sformatf("v%0d_dvalid", i), desc_valid_out, tbl[i].e_dvalid);
            chk($sformatf("v%0d_rready", i), r_ready, tbl[i].e_rready);
            chk($sformatf("v%0d_wvalid", i), way_valid, tbl[i].e_wvalid);
            chk($sformatf("v%0d_err", i), refill_err, 1'b0);
            if (tbl[i].e_wvalid) begin
                chk($sformatf("v%0d_blk", i), 64'(way_inp.blk_offset), 64'(tbl[i].e_blk));
                chk($sformatf("v%0d_data", i), way_inp.data, tbl[i].e_data);
                chk($sformatf("v%0d_line", i), 64'(way_inp.line_addr), 64'h55);
            end
        end

        // Backpressure: way stalled for 5 cycles.
        refill(64'hB0B0_0000_0000_0100, 5, 32'h0000_0AA0, 4'd1, 8'h55, 0);
        // Protocol error: early last on beat 1, SLVERR on beat 2.
        beat_last[1] = 1'b1; beat_resp[2] = 2'b10; beat_last[3] = 1'b1;
        exp_err[1] = 1'b1; exp_err[2] = 1'b1;
        refill(64'hE000_0000_0000_0200, 0, 32'h0000_1FE0, 4'd8, 8'hFF, 5);
        beat_last[1] = 1'b0; beat_resp[2] = 2'b00; exp_err[1] = 1'b0; exp_err[2] = 1'b0;

        // Downstream stall in SEND, then release together with a new descriptor.
        held = desc_out;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", desc_valid_out, 1'b1);
            chk("stall_desc", 64'(desc_out), 64'(held));
            chk("stall_rready", {r_ready, desc_ready_out}, 2'b00);
        end
        @(negedge clk);
        desc_ready_in = 1'b1; desc_valid = 1'b1;
        desc_in.a_x_addr = 32'h0000_0040; desc_in.way_ind = 4'd4; desc_in.refill = 1'b1;
        #1 chk("b2b_handshake", {desc_valid_out, desc_ready_out}, 2'b11);
        @(negedge clk);
        desc_valid = 1'b0; desc_ready_in = 1'b0;
        r_valid = 1'b1; r_chan.data = 64'hDEAD_0000_0000_0000; r_chan.last = 1'b0; way_ready = 1'b0;
        #1;
        chk("b2b_refill", {desc_valid_out, r_ready}, 2'b01);
        chk("b2b_desc", 64'(desc_out.way_ind), 64'd4);
        @(negedge clk);
        r_chan.data = 64'hDEAD_0000_0000_0001;
        #1 chk("mid_rready", r_ready, 1'b1);

        // Reset mid-refill after two accepted beats.
        @(negedge clk);
        r_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mr_dready", desc_ready_out, 1'b1);
        chk("mr_valids", {desc_valid_out, r_ready, way_valid, refill_err}, 4'b0000);
        chk("mr_desc", 64'(desc_out), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        refill(64'hC0DE_0000_0000_0300, 0, 32'h0000_0AA0, 4'd2, 8'h55, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_llc_r_master.md
# axi_llc_r_master

Refill counterpart of the LLC eviction W master. It takes a descriptor from the refill pipeline. If the descriptor's `refill` flag is set, it accepts one full cache line of R beats from the AXI master port and writes each beat into the selected data way. It then forwards the descriptor to the next unit. Descriptors without `refill` pass through unchanged.

## Interface
Parameters:
- `Cfg`, `axi_llc_pkg::llc_cfg_t'{default: '0}`: static LLC configuration; uses `NumBlocks`, `BlockOffsetLength`, `ByteOffsetLength`, `IndexLength`.
- `AxiCfg`, `axi_llc_pkg::llc_axi_cfg_t'{default: '0}`: AXI configuration; uses `DataWidthFull`.
- `desc_t`, `logic`: LLC descriptor type.
- `way_inp_t`, `logic`: data way request type.
- `r_chan_t`, `logic`: AXI R channel payload type.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous reset, active low.
- `test_i` in 1: testmode, forwarded to the FIFO.
- `desc_i` in `desc_t`: input descriptor.
- `desc_valid_i` in 1: input descriptor valid.
- `desc_ready_o` out 1: unit accepts a descriptor.
- `desc_o` out `desc_t`: output descriptor, equal to the registered descriptor.
- `desc_valid_o` out 1: output descriptor valid.
- `desc_ready_i` in 1: next unit ready.
- `r_chan_mst_i` in `r_chan_t`: AXI R payload.
- `r_chan_valid_i` in 1: R valid.
- `r_chan_ready_o` out 1: R ready.
- `way_inp_o` out `way_inp_t`: data way write request.
- `way_inp_valid_o` out 1: request valid.
- `way_inp_ready_i` in 1: data way ready.
- `refill_err_o` out 1: one-cycle pulse when a received beat carries an error.

## Operation
- States: IDLE, REFILL, SEND. Reset state is IDLE.
- IDLE:
  - `desc_ready_o`=1.
  - On `desc_valid_i`, register the descriptor.
  - Go to REFILL if `desc_i.refill`, otherwise to SEND.
  - Entering REFILL loads both counters to 0.
- REFILL, receive side:
  - `r_chan_ready_o` = ~fifo_full & ~beat_done.
  - Each R handshake pushes `data` into a 2-entry non-fall-through `fifo_v3` and increments the beat counter (width `BlockOffsetLength`).
  - Beat counter overflow sets `beat_done`; no further beats are accepted for this descriptor.
- REFILL, error check: `refill_err_o` pulses in the handshake cycle if either condition holds:
  - `resp` != OKAY;
  - `last` != (beat counter == NumBlocks-1).
  - The beat is still written. Beat count is always exactly `NumBlocks`.
- REFILL, write side:
  - `way_inp_valid_o` = ~fifo_empty.
  - `way_inp_o` fields: `cache_unit`=`RefilUnit`, `way_ind`=desc_q.way_ind, `line_addr`=desc_q.a_x_addr[ByteOffsetLength+BlockOffsetLength +: IndexLength], `blk_offset`=write counter, `we`=1, `strb`='1, `data`=FIFO head. All other fields are '0.
  - Each way handshake pops the FIFO and increments the write counter.
- REFILL exit: the handshake that overflows the write counter moves the unit to SEND.
- SEND:
  - `desc_valid_o`=1.
  - On `desc_ready_i`, behave exactly as IDLE in the same cycle: `desc_ready_o`=1, and a new descriptor may be loaded back-to-back.
  - Otherwise hold `desc_o` stable.
- Outside REFILL, `r_chan_ready_o`=0 and `way_inp_valid_o`=0.

## Timing
- Reset values:
  - all valid outputs 0;
  - `r_chan_ready_o`=0;
  - `refill_err_o`=0;
  - `desc_ready_o`=1 (IDLE);
  - `desc_o`='0;
  - counters 0;
  - FIFO empty.
- Reset mid-refill discards the FIFO contents and the descriptor, and returns the unit to IDLE.
- An R beat accepted in cycle t is presented on `way_inp_o` at the earliest in cycle t+1.
- The FIFO decouples the R channel from the data way. There is no combinational path from `way_inp_ready_i` to `r_chan_ready_o`.
- A refill with R valid and way ready every cycle takes the descriptor load cycle, then NumBlocks+1 REFILL cycles, then SEND.
- Full throughput is one beat per cycle.
- With FIFO full, `r_chan_ready_o`=0. A push and a pop in the same cycle are both legal.
- A non-refill descriptor is visible on `desc_valid_o` one cycle after it is loaded.
- Valid signals never drop before their handshake completes. Payloads are stable while valid.

## Structure
- `axi_llc_pkg` provides `llc_cfg_t`, `llc_axi_cfg_t`, the `RefilUnit` enum member, and the `refill` descriptor flag.
- State enum `r_mst_state_e` is local to the module.
- Reuses the existing `fifo_v3` and `counter` modules (two instances, both counting up).
- Uses the `FFARN` and `FFLARN` register macros.
- Natural single sub-module: the `fifo_v3` data buffer, as `i_refill_data_fifo`.

## Test plan
All scenarios use NumBlocks=4.
- **Pass-through:** non-refill descriptor, `desc_ready_i`=1 → `desc_valid_o` one cycle later; no R ready; no way requests.
- **Full-rate refill:** refill descriptor with way_ind=2, then 4 OKAY beats D0..D3 with last on D3, way ready constant → 4 writes with blk_offset 0,1,2,3, data D0..D3, we=1, strb all-ones; `desc_valid_o` after the 4th write; `refill_err_o` never set.
- **Backpressure:** way_inp_ready_i=0 for 5 cycles → `r_chan_ready_o` falls after 2 beats; no beat lost or duplicated; writes resume in order.
- **Protocol error:** beat 2 carries SLVERR, and last=1 on beat 1 → `refill_err_o` pulses on beats 1 and 2; all 4 beats are still written.
- **Downstream stall:** `desc_ready_i`=0 for 3 cycles in SEND → `desc_o` stable; no R ready. Releasing the stall while a new descriptor is presented → both handshakes occur in the same cycle.
- **Reset mid-refill:** assert `rst_ni` after 2 beats → all outputs return to reset values; the next refill writes from blk_offset 0.
